reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement buffer for the out-of-order core. Allocates result tags to dispatched
//  instructions and supplies them to the reservation stations as dest_tag. Captures results from
//  both ALU and both load broadcast ports, answers operand-readiness lookups at dispatch
//  (val*_r/val*), and commits up to two completed entries per cycle, in program order, to the register file.
// PARAMETERS
//  TAG_W    5   tag width; DEPTH = 2**TAG_W entries (32); tag = entry index
//  REG_W    5   architectural register index width
//  DATA_W   32  result width
// PORTS
//  clk          in   1                clock, rising edge
//  rst          in   1                asynchronous, active-low reset
//  flush        in   1                sync squash of all entries
//  alloc_req    in   1                dispatch wants an entry
//  alloc_rd     in   REG_W            architectural destination
//  alloc_we     in   1                instruction writes a register
//  alloc_ack    out  1                allocation accepted this cycle
//  alloc_tag    out  TAG_W            tag assigned (valid with alloc_ack)
//  full         out  1                count == DEPTH
//  empty        out  1                count == 0
//  cmp_valid    in   4                completion strobes; [0],[1] ALU, [2],[3] load
//  cmp_tag      in   4*TAG_W          port p tag at [p*TAG_W +: TAG_W]
//  cmp_value    in   4*DATA_W         port p value at [p*DATA_W +: DATA_W]
//  lk_tag       in   2*TAG_W          two operand lookup tags (rs, rt)
//  lk_ready     out  2                operand value available
//  lk_value     out  2*DATA_W         operand value (0 when not ready)
//  commit_v     out  2                slot valid; slot1 only if slot0
//  commit_we    out  2                slot writes register file
//  commit_rd    out  2*REG_W          destination per slot
//  commit_value out  2*DATA_W         value per slot
//  commit_tag   out  2*TAG_W          tag per slot
// BEHAVIOUR
//  - Per entry: busy, done, we, rd, value. head/tail carry an extra wrap bit (TAG_W+1). count is 0..DEPTH.
//  - Reset (rst=0, async): all busy/done=0, head=tail=count=0. Outputs: full=0, empty=1, alloc_ack=0,
//    commit_v=0, lk_ready=0.
//  - Alloc: alloc_ack = alloc_req & ~full & ~flush (comb). alloc_tag = tail[TAG_W-1:0] (comb).
//    On ack: entry[tail] <= busy=1, done=0, rd, we; tail++ on the clock edge.
//    full uses registered count. A full ROB refuses alloc even if a commit frees an entry that cycle.
//  - Completion: for each cmp_valid[p] whose tag hits a busy, not-done entry: done<=1, value<=cmp_value[p].
//    Two ports on the same tag: lowest p wins. Hits on non-busy or done entries are ignored.
//  - Commit (comb from registered state, gated by ~flush):
//    commit_v[0] = busy[head] & done[head].
//    commit_v[1] = commit_v[0] & busy[head+1] & done[head+1] & (count>=2).
//    head advances by the number of committed slots; count = count + ack - commits.
//    A completion in cycle N is committable no earlier than N+1.
//  - Lookup (comb, per port): lk_ready = busy & done at the tag, OR any cmp_valid hit on the tag this cycle
//    (same-cycle bypass, lowest p wins). lk_value follows the same source.
//  - Wrap-around: pointers wrap modulo DEPTH, and tags are reused after their entry commits.
//  - flush: at the next edge, all busy/done=0, head=tail=count=0. It overrides alloc, completion and
//    commit in the same cycle.
//  - rst deasserted mid-stream: all in-flight state is lost; the first tag after reset is 0.
// TESTING
//  1. Reset, then 3 allocs with rd=1,2,3 -> tags 0,1,2; alloc_ack=1 each; empty=0; count=3.
//  2. Complete tag2 (ALU0, 0x22), then tag0 (LD0, 0x00) -> next cycle only slot0 commits tag0.
//     Complete tag1 (0x11) -> next cycle tags 1 and 2 commit together, values 0x11 and 0x22.
//  3. Alloc 32 -> full=1; 33rd req gives alloc_ack=0. Complete and commit tag0 -> full=0 next cycle;
//     the next alloc gets tag 0 (wrap).
//  4. Tag5 pending; same cycle cmp_valid[2]=1, tag5, 0xDEADBEEF; lk_tag[0]=5 ->
//     lk_ready[0]=1, lk_value=0xDEADBEEF.
//  5. 10 entries live, completion and alloc in the flush cycle -> next cycle empty=1, commit_v=0;
//     the next alloc gets tag 0.
//  6. Assert rst asynchronously mid-commit -> commit_v=0 and empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch / completion / lookup / commit bundle of the
// reorder buffer.
//   master : dispatch + execution side. Drives flush, alloc_*, cmp_*, lk_tag.
//   slave  : the ROB. Drives alloc_ack/tag, full/empty, lk_ready/value, commit_*.
// Multi-port fields are flat buses, with port p at [p*W +: W].
interface reorder_buffer_if #(
  parameter int TAG_W  = 5,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
);
  logic                  flush;
  logic                  alloc_req;
  logic [REG_W-1:0]      alloc_rd;
  logic                  alloc_we;
  logic                  alloc_ack;
  logic [TAG_W-1:0]      alloc_tag;
  logic                  full;
  logic                  empty;
  logic [3:0]            cmp_valid;
  logic [4*TAG_W-1:0]    cmp_tag;
  logic [4*DATA_W-1:0]   cmp_value;
  logic [2*TAG_W-1:0]    lk_tag;
  logic [1:0]            lk_ready;
  logic [2*DATA_W-1:0]   lk_value;
  logic [1:0]            commit_v;
  logic [1:0]            commit_we;
  logic [2*REG_W-1:0]    commit_rd;
  logic [2*DATA_W-1:0]   commit_value;
  logic [2*TAG_W-1:0]    commit_tag;

  modport master (
    output flush, alloc_req, alloc_rd, alloc_we, cmp_valid, cmp_tag, cmp_value, lk_tag,
    input  alloc_ack, alloc_tag, full, empty, lk_ready, lk_value,
           commit_v, commit_we, commit_rd, commit_value, commit_tag
  );

  modport slave (
    input  flush, alloc_req, alloc_rd, alloc_we, cmp_valid, cmp_tag, cmp_value, lk_tag,
    output alloc_ack, alloc_tag, full, empty, lk_ready, lk_value,
           commit_v, commit_we, commit_rd, commit_value, commit_tag
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with 2**TAG_W entries.
//   The tag of an entry is its index.
//   Allocation hands out one tag per cycle, taken from tail.
//   Four completion ports mark entries done and capture their values:
//   ports 0 and 1 are the ALUs, ports 2 and 3 are the loads.
//   Two operand lookups return the stored value, or the value completing in
//   the same cycle.
//   Up to two done entries retire from head per cycle, in program order.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   rob  reorder_buffer_if.slave (alloc, completion, lookup, commit, flush)
module reorder_buffer #(
  parameter int TAG_W  = 5,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  reorder_buffer_if.slave   rob
);
  localparam int DEPTH = 1 << TAG_W;
  localparam logic [TAG_W:0] DEPTH_CNT = {1'b1, {TAG_W{1'b0}}};

  // Per-entry state. busy and done are reset. The payload is not reset,
  // because it is only read while busy is set.
  logic [DEPTH-1:0]  busy, done, we;
  logic [REG_W-1:0]  rd    [DEPTH];
  logic [DATA_W-1:0] value [DEPTH];

  // head and tail carry a wrap bit. Only count decides full and empty.
  logic [TAG_W:0]    head, tail, count;
  logic [TAG_W-1:0]  hidx0, hidx1, tidx;
  logic [TAG_W:0]    n_commit, n_alloc;
  logic              ack;

  // Completion decode, one result per entry. hit is set only for a busy,
  // not-done entry. When several ports carry the same tag, the lowest port wins.
  logic [DEPTH-1:0]  cmp_hit;
  logic [DATA_W-1:0] cmp_data [DEPTH];
  logic [TAG_W-1:0]  lk_idx   [2];

  assign tidx  = tail[TAG_W-1:0];
  assign hidx0 = head[TAG_W-1:0];
  assign hidx1 = hidx0 + TAG_W'(1);

  // full comes from the registered count. A commit in the same cycle does not
  // let a new entry in.
  assign rob.full      = (count == DEPTH_CNT);
  assign rob.empty     = (count == '0);
  assign ack           = rob.alloc_req & ~rob.full & ~rob.flush;
  assign rob.alloc_ack = ack;
  assign rob.alloc_tag = tidx;

  assign rob.commit_v[0] = ~rob.flush & busy[hidx0] & done[hidx0];
  assign rob.commit_v[1] = rob.commit_v[0] & busy[hidx1] & done[hidx1] &
                           (count >= (TAG_W+1)'(2));
  assign rob.commit_we    = {we[hidx1], we[hidx0]};
  assign rob.commit_rd    = {rd[hidx1], rd[hidx0]};
  assign rob.commit_value = {value[hidx1], value[hidx0]};
  assign rob.commit_tag   = {hidx1, hidx0};

  assign n_commit = (TAG_W+1)'(rob.commit_v[0]) + (TAG_W+1)'(rob.commit_v[1]);
  assign n_alloc  = (TAG_W+1)'(ack);

  always_comb begin
    cmp_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmp_data[i] = '0;
      // Scan from the highest port down, so the lowest matching port writes last.
      for (int p = 3; p >= 0; p--) begin
        if (rob.cmp_valid[p] && rob.cmp_tag[p*TAG_W +: TAG_W] == TAG_W'(i)) begin
          cmp_hit[i]  = busy[i] & ~done[i];
          cmp_data[i] = rob.cmp_value[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Lookup returns the stored value first. Otherwise it bypasses a completion
  // that lands in this cycle.
  assign lk_idx[0] = rob.lk_tag[0 +: TAG_W];
  assign lk_idx[1] = rob.lk_tag[TAG_W +: TAG_W];

  always_comb begin
    rob.lk_ready = '0;
    rob.lk_value = '0;
    for (int l = 0; l < 2; l++) begin
      if (busy[lk_idx[l]] && done[lk_idx[l]]) begin
        rob.lk_ready[l]                 = 1'b1;
        rob.lk_value[l*DATA_W +: DATA_W] = value[lk_idx[l]];
      end else if (cmp_hit[lk_idx[l]]) begin
        rob.lk_ready[l]                 = 1'b1;
        rob.lk_value[l*DATA_W +: DATA_W] = cmp_data[lk_idx[l]];
      end
    end
  end

  // Control state. The assignments are ordered: completion, then commit
  // clears, then alloc.
  // A committed entry is already done, so its done bit never conflicts with a
  // completion. Alloc only targets a free entry, because it is refused when full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rob.flush) begin
      busy  <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (cmp_hit[i]) done[i] <= 1'b1;
      if (rob.commit_v[0]) begin
        busy[hidx0] <= 1'b0;
        done[hidx0] <= 1'b0;
      end
      if (rob.commit_v[1]) begin
        busy[hidx1] <= 1'b0;
        done[hidx1] <= 1'b0;
      end
      if (ack) begin
        busy[tidx] <= 1'b1;
        done[tidx] <= 1'b0;
      end
      head  <= head + n_commit;
      tail  <= tail + n_alloc;
      count <= count + n_alloc - n_commit;
    end
  end

  // Payload has no reset. A stale payload is harmless, because busy gates every read.
  always_ff @(posedge clk) begin
    if (!rob.flush) begin
      if (ack) begin
        we[tidx] <= rob.alloc_we;
        rd[tidx] <= rob.alloc_rd;
      end
      for (int i = 0; i < DEPTH; i++)
        if (cmp_hit[i]) value[i] <= cmp_data[i];
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for reorder_buffer.
// Every accepted allocation pushes its expected commit (tag, rd, we and the
// planned result) into a queue.
// A negedge monitor pops one queue entry for each valid commit slot and compares it.
// Each scenario task checks its own cycle-specific outputs inline.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if rif ();
  reorder_buffer dut (.clk(clk), .rst(rst), .rob(rif));

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] val;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] plan [32];
  int          m_tail = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    rif.flush     = 1'b0;
    rif.alloc_req = 1'b0;
    rif.alloc_rd  = '0;
    rif.alloc_we  = 1'b0;
    rif.cmp_valid = '0;
    rif.cmp_tag   = '0;
    rif.cmp_value = '0;
    rif.lk_tag    = '0;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic we, input logic [31:0] val);
    logic [4:0] et;
    exp_t e;
    et = 5'(m_tail);
    rif.alloc_req = 1'b1;
    rif.alloc_rd  = rd;
    rif.alloc_we  = we;
    #1;
    vectors++;
    if (rif.alloc_ack !== 1'b1 || rif.alloc_tag !== et) begin
      miscompares++;
      $display("FAIL alloc: ack=%b tag=%0d, expected ack=1 tag=%0d", rif.alloc_ack, rif.alloc_tag, et);
    end
    plan[et] = val;
    e.tag = et; e.rd = rd; e.we = we; e.val = val;
    sb.push_back(e);
    m_tail++;
    tick();
    rif.alloc_req = 1'b0;
  endtask

  task automatic do_cmp(input int p, input logic [4:0] tag);
    rif.cmp_valid[p]           = 1'b1;
    rif.cmp_tag[p*5 +: 5]      = tag;
    rif.cmp_value[p*32 +: 32]  = plan[tag];
    tick();
    rif.cmp_valid[p] = 1'b0;
  endtask

  // Commit monitor
  always @(negedge clk) begin
    if (rst) begin
      if (rif.commit_v === 2'b10) begin
        vectors++;
        miscompares++;
        $display("FAIL commit_order: commit_v=%b, slot1 valid without slot0", rif.commit_v);
      end
      for (int s = 0; s < 2; s++) begin
        if (rif.commit_v[s] === 1'b1) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL commit_extra: slot%0d tag=%0d committed, none expected", s, rif.commit_tag[s*5 +: 5]);
          end else begin
            mon_e = sb.pop_front();
            if (rif.commit_tag[s*5 +: 5] !== mon_e.tag || rif.commit_rd[s*5 +: 5] !== mon_e.rd ||
                rif.commit_we[s] !== mon_e.we || rif.commit_value[s*32 +: 32] !== mon_e.val) begin
              miscompares++;
              $display("FAIL commit_slot%0d: tag=%0d rd=%0d we=%b val=%h, expected tag=%0d rd=%0d we=%b val=%h",
                       s, rif.commit_tag[s*5 +: 5], rif.commit_rd[s*5 +: 5], rif.commit_we[s],
                       rif.commit_value[s*32 +: 32], mon_e.tag, mon_e.rd, mon_e.we, mon_e.val);
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    clear_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rif.full !== 1'b0 || rif.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags: full=%b empty=%b, expected 0/1", rif.full, rif.empty);
    end
    vectors++;
    if (rif.alloc_ack !== 1'b0 || rif.commit_v !== 2'b00 || rif.lk_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_outs: ack=%b commit_v=%b lk_ready=%b, expected 0/00/00",
               rif.alloc_ack, rif.commit_v, rif.lk_ready);
    end
    rst = 1'b1;
    sb.delete();
    m_tail = 0;
    tick();
  endtask

  task automatic test_alloc_basic;
    do_alloc(5'd1, 1'b1, 32'h00);
    do_alloc(5'd2, 1'b1, 32'h11);
    do_alloc(5'd3, 1'b1, 32'h22);
    #1;
    vectors++;
    if (rif.empty !== 1'b0 || rif.full !== 1'b0) begin
      miscompares++;
      $display("FAIL alloc_flags: empty=%b full=%b, expected 0/0", rif.empty, rif.full);
    end
  endtask

  task automatic test_inorder_commit;
    do_cmp(0, 5'd2);
    #1;
    vectors++;
    if (rif.commit_v !== 2'b00) begin
      miscompares++;
      $display("FAIL head_blocked: commit_v=%b, expected 00", rif.commit_v);
    end
    do_cmp(2, 5'd0);
    #1;
    vectors++;
    if (rif.commit_v !== 2'b01 || rif.commit_tag[4:0] !== 5'd0) begin
      miscompares++;
      $display("FAIL single_commit: commit_v=%b tag0=%0d, expected 01 tag 0", rif.commit_v, rif.commit_tag[4:0]);
    end
    tick();
    do_cmp(1, 5'd1);
    #1;
    vectors++;
    if (rif.commit_v !== 2'b11 || rif.commit_tag !== {5'd2, 5'd1} ||
        rif.commit_value !== {32'h22, 32'h11}) begin
      miscompares++;
      $display("FAIL dual_commit: commit_v=%b tags=%h vals=%h, expected 11 tags 2,1 vals 22,11",
               rif.commit_v, rif.commit_tag, rif.commit_value);
    end
    tick();
    vectors++;
    if (rif.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL drained_basic: empty=%b, expected 1", rif.empty);
    end
  endtask

  task automatic test_full_wrap;
    rif.flush = 1'b1;
    tick();
    rif.flush = 1'b0;
    sb.delete();
    m_tail = 0;
    for (int i = 0; i < 32; i++)
      do_alloc(5'(i), 1'b1, (i == 5) ? 32'hDEADBEEF : (i == 7) ? 32'h77770001 : 32'h1000 + i);
    #1;
    vectors++;
    if (rif.full !== 1'b1 || rif.empty !== 1'b0) begin
      miscompares++;
      $display("FAIL full_flag: full=%b empty=%b, expected 1/0", rif.full, rif.empty);
    end
    rif.alloc_req = 1'b1;
    #1;
    vectors++;
    if (rif.alloc_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL full_refuse: ack=%b, expected 0", rif.alloc_ack);
    end
    do_cmp(0, 5'd0);
    #1;
    vectors++;
    if (rif.alloc_ack !== 1'b0 || rif.commit_v !== 2'b01 || rif.full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_commit_cycle: ack=%b commit_v=%b full=%b, expected 0/01/1",
               rif.alloc_ack, rif.commit_v, rif.full);
    end
    tick();
    rif.alloc_req = 1'b0;
    #1;
    vectors++;
    if (rif.full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_release: full=%b, expected 0", rif.full);
    end
    do_alloc(5'd9, 1'b1, 32'hA0A00000);
  endtask

  task automatic test_bypass;
    rif.cmp_valid[2]       = 1'b1;
    rif.cmp_tag[10 +: 5]   = 5'd5;
    rif.cmp_value[64 +: 32] = 32'hDEADBEEF;
    rif.lk_tag             = {5'd6, 5'd5};
    #1;
    vectors++;
    if (rif.lk_ready !== 2'b01 || rif.lk_value[31:0] !== 32'hDEADBEEF || rif.lk_value[63:32] !== 32'h0) begin
      miscompares++;
      $display("FAIL lk_bypass: ready=%b val=%h, expected 01 val 00000000deadbeef", rif.lk_ready, rif.lk_value);
    end
    tick();
    rif.cmp_valid = '0;
    #1;
    vectors++;
    if (rif.lk_ready[0] !== 1'b1 || rif.lk_value[31:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lk_stored: ready0=%b val0=%h, expected 1 deadbeef", rif.lk_ready[0], rif.lk_value[31:0]);
    end
    rif.cmp_valid           = 4'b1010;
    rif.cmp_tag[5 +: 5]     = 5'd7;
    rif.cmp_tag[15 +: 5]    = 5'd7;
    rif.cmp_value[32 +: 32] = 32'h77770001;
    rif.cmp_value[96 +: 32] = 32'h77770003;
    rif.lk_tag              = {5'd7, 5'd5};
    #1;
    vectors++;
    if (rif.lk_ready !== 2'b11 || rif.lk_value[63:32] !== 32'h77770001) begin
      miscompares++;
      $display("FAIL lk_lowest_port: ready=%b val1=%h, expected 11 77770001", rif.lk_ready, rif.lk_value[63:32]);
    end
    tick();
    clear_in();
  endtask

  task automatic test_drain;
    logic [4:0] tags [$];
    for (int t = 1; t <= 32; t++)
      if ((t % 32) != 5 && (t % 32) != 7) tags.push_back(5'(t % 32));
    for (int k = 0; k < tags.size(); k += 2) begin
      rif.cmp_valid[1]        = 1'b1;
      rif.cmp_tag[5 +: 5]     = tags[k];
      rif.cmp_value[32 +: 32] = plan[tags[k]];
      if (k + 1 < tags.size()) begin
        rif.cmp_valid[3]        = 1'b1;
        rif.cmp_tag[15 +: 5]    = tags[k+1];
        rif.cmp_value[96 +: 32] = plan[tags[k+1]];
      end
      tick();
      rif.cmp_valid = '0;
    end
    for (int c = 0; c < 100 && rif.empty !== 1'b1; c++) tick();
    vectors++;
    if (rif.empty !== 1'b1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: empty=%b pending=%0d, expected 1/0", rif.empty, sb.size());
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 10; i++) do_alloc(5'(i + 10), 1'b1, 32'hF000 + i);
    do_cmp(0, 5'd1);
    rif.flush               = 1'b1;
    rif.alloc_req           = 1'b1;
    rif.cmp_valid[0]        = 1'b1;
    rif.cmp_tag[0 +: 5]     = 5'd2;
    rif.cmp_value[0 +: 32]  = plan[2];
    #1;
    vectors++;
    if (rif.commit_v !== 2'b00 || rif.alloc_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cycle: commit_v=%b ack=%b, expected 00/0", rif.commit_v, rif.alloc_ack);
    end
    tick();
    clear_in();
    sb.delete();
    m_tail = 0;
    rif.lk_tag = {5'd1, 5'd2};
    #1;
    vectors++;
    if (rif.empty !== 1'b1 || rif.commit_v !== 2'b00 || rif.lk_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_after: empty=%b commit_v=%b lk_ready=%b, expected 1/00/00",
               rif.empty, rif.commit_v, rif.lk_ready);
    end
    do_alloc(5'd4, 1'b1, 32'h5555);
  endtask

  task automatic test_async_reset;
    do_cmp(2, 5'd0);
    #1;
    vectors++;
    if (rif.commit_v !== 2'b01) begin
      miscompares++;
      $display("FAIL pre_reset_commit: commit_v=%b, expected 01", rif.commit_v);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (rif.commit_v !== 2'b00 || rif.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: commit_v=%b empty=%b, expected 00/1", rif.commit_v, rif.empty);
    end
    sb.delete();
    m_tail = 0;
    #3;
    rst = 1'b1;
    tick();
    do_alloc(5'd6, 1'b0, 32'h6);
    do_cmp(3, 5'd0);
    tick();
    vectors++;
    if (rif.empty !== 1'b1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset_commit: empty=%b pending=%0d, expected 1/0", rif.empty, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc_basic();
    test_inorder_commit();
    test_full_wrap();
    test_bypass();
    test_drain();
    test_flush();
    test_async_reset();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
